// File: rtl/pdm_rx.sv
// pdm_rx -- PDM microphone receiver and decimator.
//
// Generates the microphone bit clock, resynchronises the 1-bit PDM stream,
// takes one bit per pdm_clk period, and decimates it with a 3rd-order CIC
// (R = 2**DECIM_LOG2, differential delay 1) into signed NBITS PCM samples.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   pdm_clk    out  microphone bit clock, period 2*CLK_DIV clk cycles
//   pdm_din    in   asynchronous PDM data from the microphone
//   dout       out  decimated PCM sample, signed NBITS, held between strobes
//   dout_valid out  one-cycle strobe marking a new dout (after warm-up)
module pdm_rx #(
  parameter int NBITS      = 16,
  parameter int CLK_DIV    = 4,
  parameter int DECIM_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    pdm_clk,
  input  logic                    pdm_din,
  output logic signed [NBITS-1:0] dout,
  output logic                    dout_valid
);

  // Filter word: R^3 = 2^(3*DECIM_LOG2) must be representable with sign.
  localparam int W  = 3 * DECIM_LOG2 + 2;
  localparam int S  = 3 * DECIM_LOG2 + 1 - NBITS;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic signed [W-1:0] SAT_MAX = {{(W-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W-NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};

  // ---------------------------------------------------------------------
  // Bit clock generator
  // ---------------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic          div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        pdm_clk <= ~pdm_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------
  logic sync_meta;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= pdm_din;
      sync_q    <= sync_meta;
    end
  end

  // Sample on the last clk cycle before pdm_clk rises: the microphone has
  // had a whole half period since the falling edge to settle its data.
  logic bit_strobe;
  assign bit_strobe = div_wrap && !pdm_clk;

  // Bit 1 -> +1, bit 0 -> -1 (all ones in two's complement).
  logic signed [W-1:0] x;
  assign x = sync_q ? W'(1) : '1;

  // ---------------------------------------------------------------------
  // Integrators (each stage consumes the previous stage's updated value)
  // ---------------------------------------------------------------------
  logic signed [W-1:0] integ [3];
  logic signed [W-1:0] integ_next [3];

  assign integ_next[0] = integ[0] + x;

  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_integ_chain
      assign integ_next[gi] = integ[gi] + integ_next[gi-1];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Decimation counter and warm-up tracking
  // ---------------------------------------------------------------------
  logic [DECIM_LOG2-1:0] dec_cnt;
  logic                  dec_wrap;
  logic [1:0]            warm_cnt;

  assign dec_wrap = bit_strobe && (dec_cnt == {DECIM_LOG2{1'b1}});

  // ---------------------------------------------------------------------
  // Combs: evaluated combinationally on the wrap strobe, input is the
  // freshly updated last integrator.
  // ---------------------------------------------------------------------
  logic signed [W-1:0] comb_dly [3];
  logic signed [W-1:0] comb_in  [3];
  logic signed [W-1:0] comb_out [3];

  assign comb_in[0] = integ_next[2];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_comb_chain
      assign comb_out[gi] = comb_in[gi] - comb_dly[gi];
      if (gi < 2) begin : g_link
        assign comb_in[gi+1] = comb_out[gi];
      end
    end
  endgenerate

  // Pipeline stage between the comb result and the scaler.
  logic signed [W-1:0] c_reg;
  logic                calc_reg;   // a decimated result is in c_reg
  logic                flag_reg;   // that result is past warm-up

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        integ[k]    <= '0;
        comb_dly[k] <= '0;
      end
      dec_cnt  <= '0;
      warm_cnt <= '0;
      c_reg    <= '0;
      calc_reg <= 1'b0;
      flag_reg <= 1'b0;
    end else begin
      calc_reg <= dec_wrap;
      flag_reg <= dec_wrap && (warm_cnt == 2'd3);
      if (bit_strobe) begin
        for (int k = 0; k < 3; k++) begin
          integ[k] <= integ_next[k];
        end
        dec_cnt <= dec_cnt + 1'b1;
      end
      if (dec_wrap) begin
        for (int k = 0; k < 3; k++) begin
          comb_dly[k] <= comb_in[k];
        end
        c_reg <= comb_out[2];
        if (warm_cnt != 2'd3) begin
          warm_cnt <= warm_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output scaling and saturation
  // ---------------------------------------------------------------------
  logic signed [W-1:0] scaled;
  logic signed [W-1:0] sat_val;

  assign scaled = c_reg >>> S;

  always_comb begin
    sat_val = scaled;
    if (scaled > SAT_MAX) begin
      sat_val = SAT_MAX;
    end else if (scaled < SAT_MIN) begin
      sat_val = SAT_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= calc_reg && flag_reg;
      if (calc_reg) begin
        dout <= sat_val[NBITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pdm_rx.sv
// tb_pdm_rx -- self-checking bench for pdm_rx with default parameters.
// A microphone model shifts a repeating bit pattern onto pdm_din on every
// pdm_clk rising edge; steady-state PCM values are checked against
// hand-computed results, plus clock, warm-up and mid-run reset sequences.
module tb_pdm_rx;

  logic               clk;
  logic               rst;
  logic               pdm_clk;
  logic               pdm_din;
  logic signed [15:0] dout;
  logic               dout_valid;

  pdm_rx #(.NBITS(16), .CLK_DIV(4), .DECIM_LOG2(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .pdm_clk    (pdm_clk),
    .pdm_din    (pdm_din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int rises = 0;
  always @(posedge clk) cyc = cyc + 1;
  always @(posedge pdm_clk) rises = rises + 1;

  // Microphone model: repeating pattern, bit 0 first.
  logic [7:0] cur_pat = 8'h01;
  int         cur_len = 1;
  int         pat_idx = 0;
  always @(posedge pdm_clk) begin
    pat_idx = (pat_idx + 1) % cur_len;
    pdm_din = cur_pat[pat_idx];
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt = chk_cnt + 1;
    if (act == exp) begin
      pass_cnt = pass_cnt + 1;
      $display("check %-24s got %0d expected %0d ok", name, act, exp);
    end else begin
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    chk_cnt = chk_cnt + 1;
    if (act >= lo && act <= hi) begin
      pass_cnt = pass_cnt + 1;
      $display("check %-24s got %0d within [%0d,%0d] ok", name, act, lo, hi);
    end else begin
      $display("FAIL %s got %0d expected within [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  // Wait (bounded) for the next dout_valid pulse; returns the cycle stamp.
  task automatic wait_valid(input string name, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (dout_valid) begin
        t  = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
  endtask

  // Wait (bounded) for pdm_clk to reach a level, sampled on negedge clk.
  task automatic wait_pclk(input logic lvl, output int t);
    t = -1000;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (pdm_clk == lvl) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic set_pattern(input logic [7:0] p, input int len);
    cur_pat = p;
    cur_len = len;
    pat_idx = 0;
    pdm_din = p[0];
  endtask

  // Hold reset for a few cycles; returns the cycle stamp at release.
  task automatic do_reset(output int t_rel);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    t_rel = cyc;
  endtask

  typedef struct {
    string       name;
    logic [7:0]  pat;
    int          len;
    int          exp_dout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  t_rel, t_a, t_b, t0, t1, t2, r_a, r_b;
    bit  ok;

    vecs[0] = '{"const_one",  8'b0000_0001, 1,  32767};
    vecs[1] = '{"const_zero", 8'b0000_0000, 1, -32768};
    vecs[2] = '{"alt_10",     8'b0000_0001, 2,      0};
    vecs[3] = '{"d75_1110",   8'b0000_0111, 4,  16384};
    vecs[4] = '{"d25_1000",   8'b0000_0001, 4, -16384};
    vecs[5] = '{"d50_1100",   8'b0000_0011, 4,      0};

    rst     = 1'b1;
    pdm_din = 1'b1;
    set_pattern(8'h01, 1);
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_pdm_clk",    int'(pdm_clk),    0);
    check("rst_dout",       int'(dout),       0);
    check("rst_dout_valid", int'(dout_valid), 0);

    // Cold start: clock shape, warm-up, valid spacing.
    rst   = 1'b0;
    t_rel = cyc;
    wait_pclk(1'b1, t0);
    check("first_toggle", t0 - t_rel, 4);
    wait_pclk(1'b0, t1);
    wait_pclk(1'b1, t2);
    check("pdm_clk_high", t1 - t0, 4);
    check("pdm_clk_low",  t2 - t1, 4);

    wait_valid("cold_first", t_a, ok);
    if (ok) begin
      check_range("cold_first_valid_at", t_a - t_rel, 2044, 2047);
      check("cold_first_dout", int'(dout), 32767);
      r_a = rises;
      wait_valid("cold_second", t_b, ok);
      if (ok) begin
        check("valid_period_cycles", t_b - t_a, 512);
        check("bits_per_output", rises - r_a, 64);
      end
    end

    // Table-driven steady-state patterns.
    for (int v = 0; v < 6; v++) begin
      set_pattern(vecs[v].pat, vecs[v].len);
      do_reset(t_rel);
      for (int k = 0; k < 4; k++) begin
        wait_valid(vecs[v].name, t_a, ok);
        if (!ok) break;
        if (k >= 1) check($sformatf("%s_out%0d", vecs[v].name, k), int'(dout), vecs[v].exp_dout);
      end
    end

    // Mid-frame one-cycle reset with constant ones.
    set_pattern(8'h01, 1);
    do_reset(t_rel);
    wait_valid("mid_pre", t_a, ok);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    t_rel = cyc;
    check("mid_rst_pdm_clk", int'(pdm_clk),    0);
    check("mid_rst_dout",    int'(dout),       0);
    check("mid_rst_valid",   int'(dout_valid), 0);
    wait_valid("mid_post", t_a, ok);
    if (ok) begin
      check_range("mid_first_valid_at", t_a - t_rel, 2044, 2047);
      check("mid_first_dout", int'(dout), 32767);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
